// File: rtl/fake_68k.sv
// MC68000 bus-master model: runs one asynchronous S0-S7 bus cycle per command, in half-clock states.
// Define FAKE68K_BERR_EN to let berr_n terminate a cycle from S4 straight to S7.
module fake_68k (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  cycle_type,
    input  logic [23:0] mock_addr,
    input  logic [15:0] mock_data_to_write,
    input  logic [2:0]  mock_fc,
    output logic [15:0] data_read,
    output logic [4:0]  mock_state,
    input  logic        dtack_n,
    input  logic        berr_n,
    output logic [2:0]  fc,
    output logic        read,
    output logic [23:0] addr,
    inout  wire  [15:0] data,
    output logic        as_n,
    output logic        uds_n,
    output logic        lds_n
);

    // Encoding keeps bits [2:0] equal to the 68000 state number; idle maps to 0.
    typedef enum logic [3:0] {
        St0    = 4'd0,
        St1    = 4'd1,
        St2    = 4'd2,
        St3    = 4'd3,
        St4    = 4'd4,
        St5    = 4'd5,
        St6    = 4'd6,
        St7    = 4'd7,
        StIdle = 4'd8
    } state_e;

    state_e      rise_q, rise_d;
    state_e      fall_q, fall_d;
    state_e      state;
    logic        rise_tog_q, fall_tog_q;
    logic        cmd_write_q, cmd_write_d;
    logic        cmd_byte_q, cmd_byte_d;
    logic [15:0] data_read_q, data_read_d;
    logic        cmd_valid;
    logic        active, armed;
    logic        addr_on, data_on, wr_phase, as_on, ds_on;
    logic        uds_sel, lds_sel;

    // Each edge domain owns one copy of the state; whichever edge toggled last holds the live one.
    assign state     = (rise_tog_q ^ fall_tog_q) ? rise_q : fall_q;
    assign cmd_valid = (cycle_type >= 3'd1) && (cycle_type <= 3'd4);

    always_comb begin
        rise_d      = state;
        cmd_write_d = cmd_write_q;
        cmd_byte_d  = cmd_byte_q;
        case (state)
            StIdle, St7: begin
                if (cmd_valid) begin
                    rise_d      = St0;
                    cmd_write_d = (cycle_type == 3'd2) || (cycle_type == 3'd4);
                    cmd_byte_d  = (cycle_type == 3'd3) || (cycle_type == 3'd4);
                end else begin
                    rise_d = StIdle;
                end
            end
            St1:     rise_d = St2;
            St3:     rise_d = St4;
            St5:     rise_d = St6;
            default: rise_d = state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q      <= StIdle;
            rise_tog_q  <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_byte_q  <= 1'b0;
        end else begin
            rise_q      <= rise_d;
            rise_tog_q  <= ~rise_tog_q;
            cmd_write_q <= cmd_write_d;
            cmd_byte_q  <= cmd_byte_d;
        end
    end

    always_comb begin
        fall_d      = state;
        data_read_d = data_read_q;
        case (state)
            St0: fall_d = St1;
            St2: fall_d = St3;
            St4: begin
                if (!dtack_n) begin
                    fall_d = St5;
                end
`ifdef FAKE68K_BERR_EN
                else if (!berr_n) begin
                    fall_d = St7;
                end
`endif
            end
            St6: begin
                fall_d = St7;
                if (!cmd_write_q) begin
                    data_read_d = data;
                end
            end
            default: fall_d = state;
        endcase
    end

`ifndef FAKE68K_BERR_EN
    logic berr_unused;
    assign berr_unused = berr_n;
`endif

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            fall_q      <= StIdle;
            fall_tog_q  <= 1'b0;
            data_read_q <= 16'h0000;
        end else begin
            fall_q      <= fall_d;
            fall_tog_q  <= ~fall_tog_q;
            data_read_q <= data_read_d;
        end
    end

    always_comb begin
        active   = (state != StIdle);
        // Function code and R/W go out as soon as a command appears, ahead of S0.
        armed    = (state == StIdle) && cmd_valid && !rst;
        addr_on  = active && (state != St0);
        wr_phase = active && cmd_write_q && (state >= St2) && (state <= St7);
        data_on  = active && cmd_write_q && (state >= St3) && (state <= St7);
        as_on    = (state >= St2) && (state <= St6);
        ds_on    = cmd_write_q ? ((state >= St4) && (state <= St6)) : as_on;
        uds_sel  = !cmd_byte_q || !mock_addr[0];
        lds_sel  = !cmd_byte_q || mock_addr[0];
    end

    assign fc         = (active || armed) ? mock_fc : 3'bzzz;
    assign read       = (active || armed) ? !wr_phase : 1'bz;
    assign addr       = addr_on ? mock_addr : {24{1'bz}};
    assign data       = data_on ? mock_data_to_write : {16{1'bz}};
    assign as_n       = !as_on;
    assign uds_n      = !(ds_on && uds_sel);
    assign lds_n      = !(ds_on && lds_sel);
    assign mock_state = {2'b00, state[2:0]};
    assign data_read  = data_read_q;

endmodule

// File: tb/tb_fake_68k.sv
// Directed bench for fake_68k; released tri-state lines are pulled up, so Z reads as all ones.
module tb_fake_68k;

    logic        clk;
    logic        rst;
    logic [2:0]  cycle_type;
    logic [23:0] mock_addr;
    logic [15:0] mock_data_to_write;
    logic [2:0]  mock_fc;
    logic [15:0] data_read;
    logic [4:0]  mock_state;
    logic        dtack_n;
    logic        berr_n;
    tri1  [2:0]  fc;
    tri1         read;
    tri1  [23:0] addr;
    tri1  [15:0] data;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;

    logic        tb_drv;
    logic [15:0] tb_data;
    int          n_checks;
    int          n_fail;

    assign data = tb_drv ? tb_data : 16'hzzzz;

    fake_68k dut (
        .clk                (clk),
        .rst                (rst),
        .cycle_type         (cycle_type),
        .mock_addr          (mock_addr),
        .mock_data_to_write (mock_data_to_write),
        .mock_fc            (mock_fc),
        .data_read          (data_read),
        .mock_state         (mock_state),
        .dtack_n            (dtack_n),
        .berr_n             (berr_n),
        .fc                 (fc),
        .read               (read),
        .addr               (addr),
        .data               (data),
        .as_n               (as_n),
        .uds_n              (uds_n),
        .lds_n              (lds_n)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag, input int st, input logic a, input logic u,
                             input logic l);
        check_eq({tag, " state"}, 32'(mock_state), 32'(st));
        check_eq({tag, " as_n"}, 32'(as_n), 32'(a));
        check_eq({tag, " uds_n"}, 32'(uds_n), 32'(u));
        check_eq({tag, " lds_n"}, 32'(lds_n), 32'(l));
    endtask

    task automatic rise();
        @(posedge clk);
        #1;
    endtask

    task automatic fall();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        clk = 1'b0;
        rst = 1'b1;
        cycle_type = 3'd0;
        mock_addr = 24'd0;
        mock_data_to_write = 16'd0;
        mock_fc = 3'd0;
        dtack_n = 1'b1;
        berr_n = 1'b1;
        tb_drv = 1'b0;
        tb_data = 16'd0;
        fall();
        fall();
        rst = 1'b0;
        rise();

        // Idle after reset
        check_bus("idle", 0, 1'b1, 1'b1, 1'b1);
        check_eq("idle fc", 32'(fc), 32'h7);
        check_eq("idle addr", 32'(addr), 32'hffffff);
        check_eq("idle data", 32'(data), 32'hffff);
        check_eq("idle data_read", 32'(data_read), 32'h0);

        // Word read with two wait states
        fall();
        cycle_type = 3'd1;
        mock_fc = 3'b011;
        mock_addr = 24'd120;
        #1;
        check_eq("arm fc", 32'(fc), 32'h3);
        check_eq("arm read", 32'(read), 32'h1);
        check_eq("arm addr", 32'(addr), 32'hffffff);
        check_bus("arm", 0, 1'b1, 1'b1, 1'b1);
        rise();
        check_bus("rd s0", 0, 1'b1, 1'b1, 1'b1);
        check_eq("rd s0 addr", 32'(addr), 32'hffffff);
        fall();
        check_bus("rd s1", 1, 1'b1, 1'b1, 1'b1);
        check_eq("rd s1 addr", 32'(addr), 32'd120);
        rise();
        check_bus("rd s2", 2, 1'b0, 1'b0, 1'b0);
        fall();
        check_bus("rd s3", 3, 1'b0, 1'b0, 1'b0);
        check_eq("rd s3 data", 32'(data), 32'hffff);
        rise();
        check_bus("rd s4", 4, 1'b0, 1'b0, 1'b0);
        cycle_type = 3'd0;
        for (int i = 0; i < 2; i++) begin
            fall();
            check_eq("rd wait fall", 32'(mock_state), 32'd4);
            rise();
            check_eq("rd wait rise", 32'(mock_state), 32'd4);
        end
        dtack_n = 1'b0;
        tb_drv = 1'b1;
        tb_data = 16'h7f7f;
        fall();
        check_bus("rd s5", 5, 1'b0, 1'b0, 1'b0);
        rise();
        check_bus("rd s6", 6, 1'b0, 1'b0, 1'b0);
        check_eq("rd s6 data_read", 32'(data_read), 32'h0);
        fall();
        check_bus("rd s7", 7, 1'b1, 1'b1, 1'b1);
        check_eq("rd s7 data_read", 32'(data_read), 32'h7f7f);
        check_eq("rd s7 addr", 32'(addr), 32'd120);
        tb_drv = 1'b0;
        rise();
        check_bus("rd end", 0, 1'b1, 1'b1, 1'b1);
        check_eq("rd end fc", 32'(fc), 32'h7);
        check_eq("rd end addr", 32'(addr), 32'hffffff);

        // Word write, DTACK already low (stale at S0)
        fall();
        cycle_type = 3'd2;
        mock_fc = 3'b101;
        mock_addr = 24'h000200;
        mock_data_to_write = 16'ha55a;
        rise();
        check_bus("wr s0", 0, 1'b1, 1'b1, 1'b1);
        check_eq("wr s0 read", 32'(read), 32'h1);
        fall();
        check_bus("wr s1", 1, 1'b1, 1'b1, 1'b1);
        rise();
        check_bus("wr s2", 2, 1'b0, 1'b1, 1'b1);
        check_eq("wr s2 read", 32'(read), 32'h0);
        check_eq("wr s2 data", 32'(data), 32'hffff);
        fall();
        check_bus("wr s3", 3, 1'b0, 1'b1, 1'b1);
        check_eq("wr s3 data", 32'(data), 32'ha55a);
        rise();
        check_bus("wr s4", 4, 1'b0, 1'b0, 1'b0);
        cycle_type = 3'd0;
        fall();
        check_bus("wr s5", 5, 1'b0, 1'b0, 1'b0);
        rise();
        check_bus("wr s6", 6, 1'b0, 1'b0, 1'b0);
        fall();
        check_bus("wr s7", 7, 1'b1, 1'b1, 1'b1);
        check_eq("wr s7 read", 32'(read), 32'h0);
        check_eq("wr s7 data", 32'(data), 32'ha55a);
        check_eq("wr data_read", 32'(data_read), 32'h7f7f);
        rise();
        check_eq("wr end state", 32'(mock_state), 32'd0);
        check_eq("wr end data", 32'(data), 32'hffff);

        // Back-to-back byte reads: odd address then even address
        fall();
        cycle_type = 3'd3;
        mock_addr = 24'd121;
        tb_drv = 1'b1;
        tb_data = 16'h1234;
        rise();
        fall();
        rise();
        check_bus("bo s2", 2, 1'b0, 1'b1, 1'b0);
        fall();
        rise();
        fall();
        rise();
        check_bus("bo s6", 6, 1'b0, 1'b1, 1'b0);
        fall();
        check_bus("bo s7", 7, 1'b1, 1'b1, 1'b1);
        check_eq("bo data_read", 32'(data_read), 32'h1234);
        mock_addr = 24'd120;
        tb_data = 16'h5678;
        rise();
        check_bus("be s0", 0, 1'b1, 1'b1, 1'b1);
        check_eq("be s0 fc", 32'(fc), 32'h5);
        fall();
        rise();
        check_bus("be s2", 2, 1'b0, 1'b0, 1'b1);
        fall();
        rise();
        cycle_type = 3'd0;
        fall();
        rise();
        check_bus("be s6", 6, 1'b0, 1'b0, 1'b1);
        fall();
        check_eq("be data_read", 32'(data_read), 32'h5678);
        tb_drv = 1'b0;
        rise();
        check_eq("be end fc", 32'(fc), 32'h7);

        // Bus error in S4 with DTACK negated
        fall();
        cycle_type = 3'd1;
        mock_addr = 24'd120;
        dtack_n = 1'b1;
        berr_n = 1'b0;
        tb_drv = 1'b1;
        tb_data = 16'hbeef;
        rise();
        fall();
        rise();
        fall();
        rise();
        check_eq("berr s4", 32'(mock_state), 32'd4);
        cycle_type = 3'd0;
        fall();
`ifdef FAKE68K_BERR_EN
        check_bus("berr s7", 7, 1'b1, 1'b1, 1'b1);
        check_eq("berr data_read", 32'(data_read), 32'h5678);
`else
        check_bus("berr ignored", 4, 1'b0, 1'b0, 1'b0);
        dtack_n = 1'b0;
        fall();
        check_eq("berr ign s5", 32'(mock_state), 32'd5);
        rise();
        fall();
        check_eq("berr ign data_read", 32'(data_read), 32'hbeef);
`endif
        rise();
        check_eq("berr end", 32'(mock_state), 32'd0);
        berr_n = 1'b1;
        dtack_n = 1'b1;
        tb_drv = 1'b0;

        // Reset asserted mid-cycle in S3
        fall();
        cycle_type = 3'd2;
        mock_data_to_write = 16'ha55a;
        rise();
        fall();
        rise();
        fall();
        check_eq("rst pre s3", 32'(mock_state), 32'd3);
        check_eq("rst pre data", 32'(data), 32'ha55a);
        #1;
        rst = 1'b1;
        #1;
        check_bus("rst", 0, 1'b1, 1'b1, 1'b1);
        check_eq("rst fc", 32'(fc), 32'h7);
        check_eq("rst addr", 32'(addr), 32'hffffff);
        check_eq("rst data", 32'(data), 32'hffff);
        check_eq("rst data_read", 32'(data_read), 32'h0);
        fall();
        cycle_type = 3'd0;
        fall();
        rst = 1'b0;
        rise();
        check_bus("post rst", 0, 1'b1, 1'b1, 1'b1);
        check_eq("post rst fc", 32'(fc), 32'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
